// File: rtl/alu_arbiter.sv
// Two-port arbiter sharing one calculator ALU: accept one op, issue it, route the result to its owner.
// Optional macro ALU_ARB_RR_EN selects round-robin tie-breaking; undefined gives fixed priority (port 0).

package calc_pkg;
  typedef logic [31:0] num_t;
  typedef enum logic [1:0] {OP_ADD, OP_SUB, OP_MUL, OP_DIV} op_t;
endpackage

module alu_arbiter (
  input  logic              clk_i,
  input  logic              rst_i,
  input  calc_pkg::num_t    req_left_i [2],
  input  calc_pkg::num_t    req_right_i [2],
  input  calc_pkg::op_t     req_op_i [2],
  input  logic [1:0]        req_in_valid_i,
  output logic [1:0]        req_in_ready_o,
  output calc_pkg::num_t    req_result_o,
  output logic [1:0]        req_out_valid_o,
  input  logic [1:0]        req_out_ready_i,
  output calc_pkg::num_t    alu_left_o,
  output calc_pkg::num_t    alu_right_o,
  output calc_pkg::op_t     alu_op_o,
  output logic              alu_in_valid_o,
  input  logic              alu_in_ready_i,
  input  calc_pkg::num_t    alu_result_i,
  input  logic              alu_out_valid_i,
  output logic              alu_out_ready_o,
  output logic              owner_o,
  output logic              busy_o
);
  import calc_pkg::*;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_COLLECT} state_t;

  state_t state_reg, state_next;
  num_t   left_reg, right_reg;
  op_t    op_reg;
  logic   owner_reg;
  logic   winner;
  logic   accept;

  // No grant is given while reset is held, so nothing is accepted into a cleared FSM.
  assign accept = (state_reg == S_IDLE) && (|req_in_valid_i) && !rst_i;

`ifdef ALU_ARB_RR_EN
  logic last_grant_reg;

  always_comb begin
    if (&req_in_valid_i) winner = ~last_grant_reg;
    else                 winner = req_in_valid_i[1] & ~req_in_valid_i[0];
  end

  always_ff @(posedge clk_i) begin
    if (rst_i)       last_grant_reg <= 1'b1;
    else if (accept) last_grant_reg <= winner;
  end
`else
  always_comb begin
    winner = req_in_valid_i[1] & ~req_in_valid_i[0];
  end
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) state_reg <= S_IDLE;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:    if (accept) state_next = S_ISSUE;
      S_ISSUE:   if (alu_in_ready_i) state_next = S_COLLECT;
      S_COLLECT: if (alu_out_valid_i && req_out_ready_i[owner_reg]) state_next = S_IDLE;
      default:   state_next = S_IDLE;
    endcase
  end

  always_comb begin
    req_in_ready_o  = 2'b00;
    req_out_valid_o = 2'b00;
    alu_in_valid_o  = 1'b0;
    alu_out_ready_o = 1'b0;
    case (state_reg)
      S_IDLE:    req_in_ready_o[winner] = accept;
      S_ISSUE:   alu_in_valid_o = 1'b1;
      S_COLLECT: begin
        alu_out_ready_o            = req_out_ready_i[owner_reg];
        req_out_valid_o[owner_reg] = alu_out_valid_i;
      end
      default: ;
    endcase
  end

  // Operands stay latched after completion so the ALU inputs only move on a new acceptance.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      left_reg  <= '0;
      right_reg <= '0;
      op_reg    <= OP_ADD;
      owner_reg <= 1'b0;
    end else if (accept) begin
      left_reg  <= req_left_i[winner];
      right_reg <= req_right_i[winner];
      op_reg    <= req_op_i[winner];
      owner_reg <= winner;
    end
  end

  assign alu_left_o   = left_reg;
  assign alu_right_o  = right_reg;
  assign alu_op_o     = op_reg;
  assign req_result_o = alu_result_i;
  assign owner_o      = owner_reg;
  assign busy_o       = (state_reg != S_IDLE);

endmodule
